// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through fetch, decode, execute,
// memory and write-back, issues commit strobes, and keeps cycle/instret counters.
module core_seq_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 64
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ifu_req,
   input  logic             ifu_ack,
   output logic             ir_wen,
   input  logic             dec_load,
   input  logic             dec_store,
   input  logic             dec_csr,
   input  logic             dec_ecall,
   input  logic             dec_mret,
   input  logic             dec_ebreak,
   input  logic             dec_illegal,
   input  logic             dec_rd_wr,
   output logic             lsu_req,
   input  logic             lsu_ack,
   output logic             pc_wen,
   output logic             reg_wen,
   output logic             csr_wen,
   output logic             intr,
   output logic             mret,
   output logic             halt,
   output logic             err,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      StReset, StFetch, StDecode, StExec, StMem, StWb, StHalt
   } state_e;

   // Last wait count that may still see its ack; one more idle cycle means timeout.
   localparam logic [9:0] WaitLast = 10'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [9:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic             load_q, store_q, csr_q, ecall_q, mret_q, rd_wr_q;
   logic [CNT_W-1:0] cycle_q, instret_q;
   logic [2:0]       n_class;

   assign n_class = {2'b0, dec_load} + {2'b0, dec_store} + {2'b0, dec_csr}
                  + {2'b0, dec_ecall} + {2'b0, dec_mret};

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      ifu_req = 1'b0;
      ir_wen  = 1'b0;
      lsu_req = 1'b0;
      pc_wen  = 1'b0;
      reg_wen = 1'b0;
      csr_wen = 1'b0;
      intr    = 1'b0;
      mret    = 1'b0;
      unique case (state_q)
         StReset: begin
            state_d = StFetch;
            wait_d  = '0;
         end
         StFetch: begin
            ifu_req = 1'b1;
            if (ifu_ack) begin
               ir_wen  = 1'b1;
               state_d = StDecode;
            end else if (wait_q == WaitLast) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 10'd1;
            end
         end
         StDecode: begin
            // Illegal (explicit or multi-class) takes priority over ebreak.
            if (dec_illegal || (n_class > 3'd1)) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else if (dec_ebreak) begin
               state_d = StHalt;
               err_d   = 1'b0;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (load_q || store_q) begin
               state_d = StMem;
               wait_d  = '0;
            end else begin
               state_d = StWb;
            end
         end
         StMem: begin
            lsu_req = 1'b1;
            if (lsu_ack) begin
               state_d = StWb;
            end else if (wait_q == WaitLast) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 10'd1;
            end
         end
         StWb: begin
            pc_wen  = 1'b1;
            reg_wen = rd_wr_q & ~store_q;
            csr_wen = csr_q;
            intr    = ecall_q;
            mret    = mret_q;
            state_d = StFetch;
            wait_d  = '0;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StReset;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StReset;
         wait_q    <= '0;
         err_q     <= 1'b0;
         load_q    <= 1'b0;
         store_q   <= 1'b0;
         csr_q     <= 1'b0;
         ecall_q   <= 1'b0;
         mret_q    <= 1'b0;
         rd_wr_q   <= 1'b0;
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         if (state_q == StDecode) begin
            load_q  <= dec_load;
            store_q <= dec_store;
            csr_q   <= dec_csr;
            ecall_q <= dec_ecall;
            mret_q  <= dec_mret;
            rd_wr_q <= dec_rd_wr;
         end
         if ((state_q != StReset) && (state_q != StHalt)) begin
            cycle_q <= cycle_q + CNT_W'(1);
         end
         if (state_q == StWb) begin
            instret_q <= instret_q + CNT_W'(1);
         end
      end
   end

   assign halt      = (state_q == StHalt);
   assign err       = err_q;
   assign cycle_cnt = cycle_q;
   assign instret   = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed and random instructions checked cycle by cycle against a
// per-instruction phase model built from the sequencing rules.
module tb_core_seq_ctrl;

   localparam int unsigned TO = 4;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req, ifu_ack, ir_wen, lsu_req, lsu_ack;
   logic          dec_load, dec_store, dec_csr, dec_ecall, dec_mret, dec_ebreak, dec_illegal;
   logic          dec_rd_wr;
   logic          pc_wen, reg_wen, csr_wen, intr, mret, halt, err;
   logic [CW-1:0] cycle_cnt, instret;

   core_seq_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ir_wen(ir_wen),
      .dec_load(dec_load), .dec_store(dec_store), .dec_csr(dec_csr), .dec_ecall(dec_ecall),
      .dec_mret(dec_mret), .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
      .dec_rd_wr(dec_rd_wr), .lsu_req(lsu_req), .lsu_ack(lsu_ack), .pc_wen(pc_wen),
      .reg_wen(reg_wen), .csr_wen(csr_wen), .intr(intr), .mret(mret), .halt(halt), .err(err),
      .cycle_cnt(cycle_cnt), .instret(instret)
   );

   always #5 clk = ~clk;

   wire [9:0] outs = {ifu_req, ir_wen, lsu_req, pc_wen, reg_wen, csr_wen, intr, mret, halt, err};

   int            n_total = 0;
   int            n_pass  = 0;
   int            n_fail  = 0;
   logic [CW-1:0] m_cycle, m_instret;
   logic          m_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      assert (got === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output vector: {ifu_req, ir_wen, lsu_req, pc_wen, reg_wen, csr_wen, intr, mret, halt, err}
   function automatic logic [9:0] ev(bit a, bit b, bit c, bit d, bit e, bit f, bit g, bit h,
                                     bit i, bit j);
      return {a, b, c, d, e, f, g, h, i, j};
   endfunction

   // Inputs are applied 1 time unit after a rising edge; outputs are sampled on the falling edge.
   task automatic tick(input string tag, input logic [9:0] exp);
      #4;
      chk({tag, " outs"}, 64'(outs), 64'(exp));
      chk({tag, " cycle_cnt"}, 64'(cycle_cnt), 64'(m_cycle));
      chk({tag, " instret"}, 64'(instret), 64'(m_instret));
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      {dec_load, dec_store, dec_csr, dec_ecall, dec_mret, dec_ebreak, dec_illegal, dec_rd_wr} =
         8'($urandom);
      ifu_ack = 1'($urandom);
      lsu_ack = 1'($urandom);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      noise();
      ifu_ack = 1'b0;
      lsu_ack = 1'b0;
      @(posedge clk);
      #1;
      m_cycle   = '0;
      m_instret = '0;
      m_err     = 1'b0;
      for (int i = 1; i < n; i++) begin
         noise();
         tick("reset", 10'b0);
      end
      rst = 1'b0;
      noise();
      tick("release", 10'b0);
   endtask

   task automatic halted(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         tick(tag, ev(0, 0, 0, 0, 0, 0, 0, 0, 1, m_err));
      end
   endtask

   // Request phase: ack arrives after w idle cycles; w >= TO means it never arrives in time.
   task automatic phase(input string tag, input bit is_fetch, input int w, input int abort,
                        output bit ok);
      int n;
      n  = (w < int'(TO)) ? w + 1 : int'(TO);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         noise();
         if (is_fetch) begin
            ifu_ack = (i == w);
            tick(tag, ev(1, i == w, 0, 0, 0, 0, 0, 0, 0, 0));
         end else begin
            lsu_ack = (i == w);
            tick(tag, ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
         end
         m_cycle++;
         if (i == abort) begin
            ok = 1'b0;
            return;
         end
      end
      if (w >= int'(TO)) begin
         m_err = 1'b1;
         ok    = 1'b0;
      end
   endtask

   // f = {load, store, csr, ecall, mret, ebreak, illegal, rd_wr}
   task automatic run_instr(input string tag, input logic [7:0] f, input int wf, input int wm,
                            input int abort_mem);
      bit ld, st, cs, ec, mr, eb, il, rd, ok;
      int nsel;
      {ld, st, cs, ec, mr, eb, il, rd} = f;
      phase({tag, " fetch"}, 1'b1, wf, -1, ok);
      if (!ok) return;
      noise();
      {dec_load, dec_store, dec_csr, dec_ecall, dec_mret, dec_ebreak, dec_illegal, dec_rd_wr} = f;
      tick({tag, " decode"}, 10'b0);
      m_cycle++;
      nsel = int'(ld) + int'(st) + int'(cs) + int'(ec) + int'(mr);
      if (il || nsel > 1) begin
         m_err = 1'b1;
         return;
      end
      if (eb) begin
         m_err = 1'b0;
         return;
      end
      noise();
      tick({tag, " exec"}, 10'b0);
      m_cycle++;
      if (ld || st) begin
         phase({tag, " mem"}, 1'b0, wm, abort_mem, ok);
         if (!ok) return;
      end
      noise();
      tick({tag, " wb"}, ev(0, 0, 0, 1, rd & ~st, cs, ec, mr, 0, 0));
      m_cycle++;
      m_instret++;
   endtask

   initial begin
      logic [7:0] f;
      int         c;
      rst = 1'b1;
      noise();
      @(posedge clk);
      #1;

      do_reset(3);
      run_instr("first", 8'b0000_0001, 0, 0, -1);
      chk("instret after first", 64'(instret), 64'd1);

      run_instr("load_wait3", 8'b1000_0001, 0, 3, -1);
      run_instr("store_rd", 8'b0100_0001, 1, 0, -1);
      run_instr("csr", 8'b0010_0001, 0, 0, -1);
      run_instr("ecall", 8'b0001_0000, 2, 0, -1);
      run_instr("mret", 8'b0000_1000, 0, 0, -1);

      for (int k = 0; k < 30; k++) begin
         f = 8'b0;
         c = int'($urandom_range(0, 5));
         if (c > 0) f[8-c] = 1'b1;
         f[0] = 1'($urandom);
         run_instr("rand", f, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      end

      run_instr("ebreak", 8'b0000_0101, 1, 0, -1);
      halted("ebreak halt", 5);

      do_reset(2);
      run_instr("pre_ill", 8'b0000_0001, 0, 0, -1);
      run_instr("load_csr", 8'b1010_0001, 0, 0, -1);
      halted("illegal halt", 5);

      do_reset(2);
      run_instr("illegal_ebreak", 8'b0000_0110, 0, 0, -1);
      halted("ill_over_ebreak", 3);

      do_reset(2);
      run_instr("fetch_timeout", 8'b0000_0001, int'(TO), 0, -1);
      halted("fetch timeout halt", 4);

      do_reset(2);
      run_instr("fetch_ack_last", 8'b0000_0001, int'(TO) - 1, 0, -1);
      run_instr("mem_timeout", 8'b0100_0000, 0, int'(TO), -1);
      halted("mem timeout halt", 4);

      do_reset(2);
      run_instr("pre_abort", 8'b0010_0000, 0, 0, -1);
      run_instr("abort_mem", 8'b1000_0001, 0, 3, 1);
      do_reset(2);
      run_instr("after_abort", 8'b1000_0001, 1, 1, -1);
      run_instr("after_abort2", 8'b0000_0001, 0, 0, -1);
      chk("instret after restart", 64'(instret), 64'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
